// File: rtl/mix_columns_seq_pkg.sv
// mix_columns_seq_pkg: shared AES constants, FSM encodings and byte/column slice helpers
// for the sequenced MixColumns engine.
package mix_columns_seq_pkg;

   localparam int AES_COLS      = 4;
   localparam int AES_ROWS      = 4;
   localparam int MC_FWD_CYCLES = 4;
   localparam int MC_INV_PHASES = 3;

   localparam logic [7:0] AES_XTIME_POLY = 8'h1b;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   localparam logic [1:0] MC_LAST_COL   = 2'(AES_COLS - 1);
   localparam logic [1:0] MC_LAST_PHASE = 2'(MC_INV_PHASES - 1);

   // Column c occupies [127-32c -: 32]; row r of a column occupies [31-8r -: 8].
   function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
      return s[32*(3-int'(c)) +: 32];
   endfunction

   function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] c,
                                            input logic [31:0] v);
      logic [127:0] r;
      r = s;
      r[32*(3-int'(c)) +: 32] = v;
      return r;
   endfunction

   function automatic logic [7:0] get_byte(input logic [31:0] col, input int r);
      return col[8*(3-r) +: 8];
   endfunction

   // Rotating left by n bytes puts row r+n of the input in row r of the result.
   function automatic logic [31:0] col_rotl(input logic [31:0] x, input int n);
      case (n)
         1:       return {x[23:0], x[31:24]};
         2:       return {x[15:0], x[31:16]};
         3:       return {x[7:0],  x[31:8]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/mix_columns_seq_xtime.sv
// mix_columns_seq_xtime: multiply one byte by 2 in GF(2^8) modulo the AES polynomial.
module mix_columns_seq_xtime
   import mix_columns_seq_pkg::*;
(
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   assign data_o = {data_i[6:0], 1'b0} ^ (data_i[7] ? AES_XTIME_POLY : 8'h00);

endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: AES MixColumns over a 128-bit state, one column at a time through four
// shared xtime units. Define MIX_COLUMNS_INV_EN to build the inverse path selected by `mode`.
module mix_columns_seq
   import mix_columns_seq_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [127:0] state_in,
   output logic [127:0] state_out,
   output logic         busy,
   output logic         done
);

   logic [1:0]   fsm_q, fsm_d;
   logic [1:0]   col_q, col_d;
   logic [127:0] state_q, state_d;
   logic [31:0]  col_b;
   logic [31:0]  xt_in_col;
   logic [31:0]  xt_out_col;
   logic [31:0]  fwd_col;
   logic [31:0]  mix_col;
   logic         col_done;

`ifdef MIX_COLUMNS_INV_EN
   logic         mode_q, mode_d;
   logic [1:0]   phase_q, phase_d;
   logic [31:0]  t1_q, t1_d;
   logic [31:0]  t2_q, t2_d;
   logic [31:0]  m9, m11, m13, m14, inv_col;
`endif

   assign col_b = get_col(state_q, col_q);

   for (genvar r = 0; r < AES_ROWS; r++) begin : g_xtime
      mix_columns_seq_xtime u_xtime (
         .data_i (get_byte(xt_in_col, r)),
         .data_o (xt_out_col[8*(3-r) +: 8])
      );
   end

   assign fwd_col = xt_out_col ^ col_rotl(xt_out_col, 1)
                  ^ col_rotl(col_b, 1) ^ col_rotl(col_b, 2) ^ col_rotl(col_b, 3);

`ifdef MIX_COLUMNS_INV_EN
   // The shared xtime units see b, then 2b, then 4b; their output in phase 2 is 8b.
   always_comb begin
      xt_in_col = col_b;
      if (mode_q) begin
         if (phase_q == 2'd1)      xt_in_col = t1_q;
         else if (phase_q == 2'd2) xt_in_col = t2_q;
      end
   end

   assign m9      = xt_out_col ^ col_b;
   assign m11     = xt_out_col ^ t1_q ^ col_b;
   assign m13     = xt_out_col ^ t2_q ^ col_b;
   assign m14     = xt_out_col ^ t2_q ^ t1_q;
   assign inv_col = m14 ^ col_rotl(m11, 1) ^ col_rotl(m13, 2) ^ col_rotl(m9, 3);

   assign mix_col  = mode_q ? inv_col : fwd_col;
   assign col_done = !mode_q || (phase_q == MC_LAST_PHASE);
`else
   logic unused_mode;

   assign unused_mode = mode;
   assign xt_in_col   = col_b;
   assign mix_col     = fwd_col;
   assign col_done    = 1'b1;
`endif

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
      fsm_d   = fsm_q;
      col_d   = col_q;
      state_d = state_q;
`ifdef MIX_COLUMNS_INV_EN
      mode_d  = mode_q;
      phase_d = phase_q;
      t1_d    = t1_q;
      t2_d    = t2_q;
`endif
      case (fsm_q)
         ST_RUN: begin
`ifdef MIX_COLUMNS_INV_EN
            if (mode_q) begin
               if (phase_q == 2'd0) t1_d = xt_out_col;
               if (phase_q == 2'd1) t2_d = xt_out_col;
               phase_d = col_done ? 2'd0 : phase_q + 2'd1;
            end
`endif
            if (col_done) begin
               state_d = set_col(state_q, col_q, mix_col);
               col_d   = col_q + 2'd1;
               if (col_q == MC_LAST_COL) fsm_d = ST_FIN;
            end
         end
         default: begin
            // IDLE and FIN both accept a start; without one, FIN drops back to IDLE.
            fsm_d = ST_IDLE;
            if (start) begin
               fsm_d   = ST_RUN;
               state_d = state_in;
               col_d   = 2'd0;
`ifdef MIX_COLUMNS_INV_EN
               mode_d  = mode;
               phase_d = 2'd0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment; reset is synchronous, checked at the edge.
      if (rst) begin
         fsm_q   <= ST_IDLE;
         col_q   <= 2'd0;
         state_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         col_q   <= col_d;
         state_q <= state_d;
      end
   end

`ifdef MIX_COLUMNS_INV_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= 1'b0;
         phase_q <= 2'd0;
         t1_q    <= '0;
         t2_q    <= '0;
      end else begin
         mode_q  <= mode_d;
         phase_q <= phase_d;
         t1_q    <= t1_d;
         t2_q    <= t2_d;
      end
   end
`endif

   assign state_out = state_q;
   assign busy      = (fsm_q == ST_RUN);
   assign done      = (fsm_q == ST_FIN);

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: scoreboard bench for mix_columns_seq; expected results come from a
// reference GF(2^8) matrix model and are compared when the DUT pulses done.
module tb_mix_columns_seq;

   localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         mode;
   logic [127:0] state_in;
   logic [127:0] state_out;
   logic         busy;
   logic         done;
   logic [7:0]   xt_a;
   logic [7:0]   xt_y;

   typedef struct {
      logic [127:0] state;
      int           cyc;
      int           n_run;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   busy_run = 0;

   mix_columns_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .state_in  (state_in),
      .state_out (state_out),
      .busy      (busy),
      .done      (done)
   );

   mix_columns_seq_xtime u_xt (
      .data_i (xt_a),
      .data_o (xt_y)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] coef(input logic inv, input int k);
      case (k)
         0:       return inv ? 8'h0e : 8'h02;
         1:       return inv ? 8'h0b : 8'h03;
         2:       return inv ? 8'h0d : 8'h01;
         default: return inv ? 8'h09 : 8'h01;
      endcase
   endfunction

   function automatic logic [127:0] mc_model(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [7:0]   acc;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(coef(inv, (j - r) & 3), s[127-32*c-8*j -: 8]);
            o[127-32*c-8*r -: 8] = acc;
         end
      end
      return o;
   endfunction

   // Pops the scoreboard on every done and checks result, latency and busy length.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         check("done_expected", 128'(sb.size() != 0), 128'(1));
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("result",      state_out,       mon_e.state);
            check("latency",     128'(cyc),       128'(mon_e.cyc));
            check("busy_cycles", 128'(busy_run),  128'(mon_e.n_run));
            check("busy_in_fin", 128'(busy),      128'(0));
         end
         busy_run = 0;
      end else if (busy === 1'b1) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic start_pass(input logic [127:0] s, input logic m);
      exp_t e;
      logic inv;
`ifdef MIX_COLUMNS_INV_EN
      inv = m;
`else
      inv = 1'b0;
`endif
      e.state = mc_model(s, inv);
      e.n_run = inv ? 12 : 4;
      e.cyc   = cyc + 1 + e.n_run;
      sb.push_back(e);
      state_in = s;
      mode     = m;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      state_in = rand128();
      mode     = 1'($urandom);
   endtask

   task automatic wait_drain(input string tag);
      int i;
      i = 0;
      while (sb.size() != 0 && i < 100) begin
         @(posedge clk); #1;
         i++;
      end
      check({tag, "_drain"}, 128'(sb.size()), 128'(0));
   endtask

   task automatic wait_fin(input string tag);
      int i;
      i = 0;
      while (done !== 1'b1 && i < 100) begin
         @(posedge clk); #1;
         i++;
      end
      check({tag, "_fin"}, 128'(done), 128'(1));
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      mode     = 1'b0;
      state_in = '0;
      xt_a     = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("reset_state_out", state_out, 128'h0);
      check("reset_busy",      128'(busy), 128'(0));
      check("reset_done",      128'(done), 128'(0));

      xt_a = 8'h57; #1 check("xtime_57", 128'(xt_y), 128'(8'hae));
      xt_a = 8'hae; #1 check("xtime_ae", 128'(xt_y), 128'(8'h47));
      xt_a = 8'h47; #1 check("xtime_47", 128'(xt_y), 128'(8'h8e));
      @(posedge clk); #1;

      start_pass(FIPS_IN, 1'b0);
      wait_drain("fwd");
      check("fwd_vector", state_out, FIPS_OUT);
      check("idle_hold_busy", 128'(busy), 128'(0));

`ifdef MIX_COLUMNS_INV_EN
      start_pass(FIPS_OUT, 1'b1);
      wait_drain("inv");
      check("inv_vector", state_out, FIPS_IN);
`else
      start_pass(FIPS_IN, 1'b1);
      wait_drain("mode_ignored");
      check("mode_ignored_col0", 128'(state_out[127:96]), 128'(32'h8e4da1bc));
`endif

      // Back-to-back: second start lands in the FIN cycle of the first pass.
      start_pass(rand128(), 1'b1);
      wait_fin("b2b_a");
      start_pass(rand128(), 1'b0);
      wait_fin("b2b_b");
      start_pass(rand128(), 1'b1);
      wait_drain("b2b");

      // A start pulsed during RUN must not disturb the pass in flight.
      start_pass(rand128(), 1'b1);
      @(posedge clk); #1;
      start    = 1'b1;
      state_in = rand128();
      mode     = 1'b0;
      @(posedge clk); #1;
      start    = 1'b0;
      wait_drain("ignored_start");

      // Reset in RUN cycle 2 aborts the pass; no done may follow.
      start_pass(rand128(), 1'b1);
      @(posedge clk); #1;
      sb.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_state_out", state_out, 128'h0);
      check("abort_busy",      128'(busy), 128'(0));
      check("abort_done",      128'(done), 128'(0));
      repeat (16) @(posedge clk);
      #1;

      // Reset and start together: reset wins.
      rst      = 1'b1;
      start    = 1'b1;
      state_in = rand128();
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      check("rst_wins_busy",      128'(busy), 128'(0));
      check("rst_wins_state_out", state_out, 128'h0);
      repeat (16) @(posedge clk);
      #1;

      start_pass(FIPS_IN, 1'b0);
      wait_drain("post_reset");
      check("post_reset_vector", state_out, FIPS_OUT);

      for (int k = 0; k < 6; k++) begin
         start_pass(rand128(), 1'($urandom));
         wait_fin("rand");
      end
      wait_drain("rand");
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
